// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants.
// Fetch FSM states, boot/halt words and the IF/ID bundle.
package pipeline_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC   = 32'h0000_3000;
  localparam logic [XLEN-1:0] HALT_INSTR = 32'h0000_000C;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT,
    FAULT
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } if_id_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus: IM address/data, hazard/redirect
// inputs and the IF/ID bundle towards decode.
interface fetch_ctrl_if;
  import pipeline_pkg::*;

  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] im_instr;
  logic [XLEN-1:0] pc;
  logic            id_valid;
  logic [XLEN-1:0] id_instr;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_pc4;
  logic            halted;
  logic            fault;
  logic [XLEN-1:0] fetch_count;

  modport master (
    input  stall, redirect_valid, redirect_pc, im_instr,
    output pc, id_valid, id_instr, id_pc, id_pc4,
    output halted, fault, fetch_count
  );

  modport slave (
    output stall, redirect_valid, redirect_pc, im_instr,
    input  pc, id_valid, id_instr, id_pc, id_pc4,
    input  halted, fault, fetch_count
  );

endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: PC register, IF/ID capture
// and the BOOT/RUN/HALT/FAULT fetch sequencer.
module fetch_ctrl
  import pipeline_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  fetch_ctrl_if.master bus
);

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] cnt_q;
  if_id_t          ifid_q;
  logic            halted_q;
  logic            fault_q;

  logic rd_bad;
  logic rd_ok;
  logic hold;
  logic go;
  logic is_halt;

  // Mutually exclusive terms so the decoder can be a unique case.
  assign rd_bad  = bus.redirect_valid & (bus.redirect_pc[1:0] != 2'b00);
  assign rd_ok   = bus.redirect_valid & (bus.redirect_pc[1:0] == 2'b00);
  assign hold    = ~bus.redirect_valid & bus.stall;
  assign go      = ~bus.redirect_valid & ~bus.stall;
  assign is_halt = (bus.im_instr == HALT_INSTR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      ifid_q   <= '{valid: 1'b0, instr: '0, pc: '0, pc4: 32'd4};
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      unique case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          unique case (1'b1)
            rd_bad: begin
              ifid_q.valid <= 1'b0;
              fault_q      <= 1'b1;
              state_q      <= FAULT;
            end
            rd_ok: begin
              pc_q         <= bus.redirect_pc;
              ifid_q.valid <= 1'b0;
            end
            hold: ;
            go: begin
              ifid_q <= '{valid: 1'b1,
                          instr: bus.im_instr,
                          pc:    pc_q,
                          pc4:   pc_q + 32'd4};
              cnt_q  <= cnt_q + 32'd1;
              if (is_halt) begin
                state_q  <= HALT;
                halted_q <= 1'b1;
              end else begin
                pc_q <= pc_q + 32'd4;
              end
            end
            default: ;
          endcase
        end
        HALT: begin
          unique case (1'b1)
            rd_bad: begin
              ifid_q.valid <= 1'b0;
              halted_q     <= 1'b0;
              fault_q      <= 1'b1;
              state_q      <= FAULT;
            end
            rd_ok: begin
              pc_q         <= bus.redirect_pc;
              ifid_q.valid <= 1'b0;
              halted_q     <= 1'b0;
              state_q      <= RUN;
            end
            hold: ;
            go: ifid_q.valid <= 1'b0;
            default: ;
          endcase
        end
        FAULT: ;
        default: ;
      endcase
    end
  end

  assign bus.pc          = pc_q;
  assign bus.id_valid    = ifid_q.valid;
  assign bus.id_instr    = ifid_q.instr;
  assign bus.id_pc       = ifid_q.pc;
  assign bus.id_pc4      = ifid_q.pc4;
  assign bus.halted      = halted_q;
  assign bus.fault       = fault_q;
  assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random
// stall/redirect/reset traffic against a reference model.
module tb_fetch_ctrl;
  import pipeline_pkg::*;

  localparam int S_BOOT  = 0;
  localparam int S_RUN   = 1;
  localparam int S_HALT  = 2;
  localparam int S_FAULT = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_ctrl_if bus();
  logic [31:0] mem [1024];
  assign bus.im_instr = mem[bus.pc[11:2]];

  fetch_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  int          m_st;
  logic [31:0] m_pc, m_instr, m_idpc, m_idpc4, m_cnt;
  logic        m_idv;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("pc", bus.pc, m_pc);
    check("id_valid", 32'(bus.id_valid), 32'(m_idv));
    check("id_instr", bus.id_instr, m_instr);
    check("id_pc", bus.id_pc, m_idpc);
    check("id_pc4", bus.id_pc4, m_idpc4);
    check("halted", 32'(bus.halted), 32'(m_st == S_HALT));
    check("fault", 32'(bus.fault), 32'(m_st == S_FAULT));
    check("fetch_count", bus.fetch_count, m_cnt);
  endtask

  task automatic model_reset();
    m_st = S_BOOT; m_pc = 32'h3000; m_idv = 1'b0;
    m_instr = 0; m_idpc = 0; m_idpc4 = 4; m_cnt = 0;
  endtask

  task automatic model_step(input logic s, input logic rv,
                            input logic [31:0] rpc);
    logic [31:0] w;
    logic        bad;
    w   = mem[m_pc[11:2]];
    bad = rv && (rpc % 4 != 0);
    case (m_st)
      S_BOOT: m_st = S_RUN;
      S_RUN, S_HALT: begin
        if (bad) begin
          m_idv = 0; m_st = S_FAULT;
        end else if (rv) begin
          m_pc = rpc; m_idv = 0; m_st = S_RUN;
        end else if (s) begin
        end else if (m_st == S_HALT) begin
          m_idv = 0;
        end else begin
          m_instr = w; m_idpc = m_pc; m_idpc4 = m_pc + 4;
          m_idv = 1; m_cnt = m_cnt + 1;
          if (w == 32'h0000_000C) m_st = S_HALT;
          else m_pc = m_pc + 4;
        end
      end
      default: ;
    endcase
  endtask

  task automatic step(input logic s, input logic rv,
                      input logic [31:0] rpc);
    bus.stall = s; bus.redirect_valid = rv; bus.redirect_pc = rpc;
    @(posedge clk);
    model_step(s, rv, rpc);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
    rst_n = 1'b1;
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    check("async_pc", bus.pc, 32'h3000);
    @(negedge clk);
    bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    logic        s, rv;
    logic [31:0] rpc;
    rst_n = 1'b0;
    bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h2008_0001 + i;
    mem[3] = 32'h0000_000C;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    step(0, 0, 0);
    check("boot_nocap", 32'(bus.id_valid), 32'd0);
    step(0, 0, 0);
    check("first_idpc", bus.id_pc, 32'h3000);
    step(0, 0, 0);
    check("second_idpc", bus.id_pc, 32'h3004);
    repeat (3) step(1, 0, 0);
    check("stall_pc", bus.pc, 32'h3008);
    check("stall_cnt", bus.fetch_count, 32'd2);
    step(0, 0, 0);
    check("resume_idpc", bus.id_pc, 32'h3008);
    check("cnt3", bus.fetch_count, 32'd3);
    step(0, 0, 0);
    check("halt_word", bus.id_instr, 32'h0000_000C);
    step(0, 0, 0);
    check("halted", 32'(bus.halted), 32'd1);
    check("halt_pc", bus.pc, 32'h300C);
    step(1, 0, 0);
    step(0, 1, 32'h3100);
    check("unhalt", 32'(bus.halted), 32'd0);
    step(0, 0, 0);
    check("unhalt_idpc", bus.id_pc, 32'h3100);
    step(1, 1, 32'h3040);
    check("rd_stall_pc", bus.pc, 32'h3040);
    check("rd_bubble", 32'(bus.id_valid), 32'd0);
    step(0, 0, 0);
    check("rd_idpc", bus.id_pc, 32'h3040);
    step(0, 1, 32'h3002);
    check("fault", 32'(bus.fault), 32'd1);
    step(0, 1, 32'h3200);
    step(0, 0, 0);
    check("fault_pc", bus.pc, 32'h3044);
    @(negedge clk);
    do_reset();
    check("rst_pc", bus.pc, 32'h3000);
    repeat (4) step(0, 0, 0);
    async_reset();

    for (int i = 0; i < 1024; i++)
      mem[i] = ($urandom % 8 == 0) ? 32'h0000_000C : $urandom;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom % 300 == 0 ||
          (m_st == S_FAULT && $urandom % 10 == 0)) begin
        async_reset();
      end else begin
        s   = ($urandom % 4 == 0);
        rv  = ($urandom % 6 == 0);
        rpc = 32'h3000 + ($urandom_range(0, 1023) << 2);
        if ($urandom % 20 == 0) rpc = 32'hFFFF_FFF8;
        if ($urandom % 30 == 0) rpc[1:0] = 2'($urandom_range(1, 3));
        step(s, rv, rpc);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
